fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory. It owns the PC, drives the instruction memory address, captures the returned word into the IF/ID pipeline register, and applies redirects: EX branch, ID jump/JAL, and ID jump-register (JS). It also detects the Halt opcode and freezes fetch so the program ends cleanly.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OPCODE, 6'b101101, inst[31:26] value that marks Halt
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on bubble or flush

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit stall; holds PC and IF/ID
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target address
jump_en  in  1  ID-stage J/JAL decoded
jump_index  in  26  ID-stage inst[25:0]
jr_en  in  1  ID-stage JS decoded, forwarded register valid
jr_target  in  32  forwarded register value (R31 for JS)
inst_in  in  32  instruction word from instruction memory, combinational on pc_out
pc_out  out  32  current PC, the instruction memory byte address
if_id_inst  out  32  registered instruction
if_id_pc_plus4  out  32  registered PC+4 of if_id_inst
if_id_valid  out  1  if_id_inst is a real instruction, not a bubble
halted  out  1  fetch frozen by Halt
fetch_count  out  32  count of valid instructions delivered to IF/ID

Behaviour:
- Reset (asynchronous, active-high) sets:
  - pc_out=RESET_PC
  - if_id_inst=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0
  - halted=0, fetch_count=0, state=RUN
- Instruction memory read is combinational, so fetch latency is 1 cycle: the inst_in sampled at edge N appears on if_id_inst after edge N.
- Redirect priority, highest first:
  - branch_taken → branch_target
  - jr_en → jr_target
  - jump_en → {if_id_pc_plus4[31:28], jump_index, 2'b00}
- Every redirect target has bits [1:0] forced to 0.
- Any redirect, at the clock edge:
  - pc_out takes the target.
  - IF/ID loads NOP_WORD with valid=0; the wrong-path word in IF is discarded.
  - Overrides stall.
  - Does not increment fetch_count.
- Stall with no redirect: PC, IF/ID and fetch_count all hold.
- Otherwise in RUN: pc_out ← pc_out+4 (32-bit wrap at 2^32), if_id_inst ← inst_in, if_id_pc_plus4 ← pc_out+4, if_id_valid ← 1, fetch_count += 1 (wraps).
- State machine:
  - RUN: on a normal advance where inst_in[31:26]==HALT_OPCODE:
    - The Halt word is latched into IF/ID as valid, so downstream sees it once.
    - pc_out ← halt address+4.
    - Next state HALTED, halted=1.
  - HALTED:
    - pc_out holds. IF/ID loads NOP_WORD, valid=0, every cycle, so it holds a bubble from the next edge on.
    - stall is ignored.
    - A redirect (from an older in-flight branch/jump) means the Halt was wrong-path: apply the redirect as above, clear halted, return to RUN.
- A Halt word in IF during a redirect or stall cycle is not acted on.
- Only reset leaves HALTED with no redirect.
- Reset asserted mid-operation overrides everything, in any state.

Decomposition:
- Shared package mips_pkg holds:
  - OP_HALT, OP_J, OP_JAL opcode constants
  - NOP_WORD
  - fetch state encoding: FETCH_RUN, FETCH_HALTED
- Sub-module if_id_reg: IF/ID register with load/hold/flush controls and an asynchronous reset.
- fetch_unit keeps the PC register, next-PC mux, halt FSM and counter.

Test Plan:
- Reset, 3 sequential ADDs at 0/4/8 → pc_out 0,4,8,12; if_id_pc_plus4 4,8,12; fetch_count=3; if_id_valid=1 each cycle.
- JAL index 4 in ID while IF holds address 8 → next pc_out=16, if_id_valid=0 for one cycle, fetch_count not incremented for the flushed word.
- jr_en with jr_target=32'h14 and branch_taken target 32'h40 in the same cycle → pc_out=32'h40 (EX wins); jr_target 32'h16 alone → pc_out=32'h14.
- stall held 2 cycles → pc_out and if_id_inst unchanged; stall plus branch_taken target 0x20 → pc_out=0x20, IF/ID bubble.
- Halt at 12 → if_id_inst=Halt valid for 1 cycle, then halted=1, pc_out=16 constant for 10 cycles, if_id_valid=0; then branch_taken target 4 → halted=0, pc_out=4.
- Assert reset while HALTED and while stalled → all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, bubble word and fetch state encoding.
package mips_pkg;

  localparam logic [5:0]  OP_HALT  = 6'b101101;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word, otherwise hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] FLUSH_WORD = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc_plus4,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush beats load; pc_plus4 is left alone on a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst     <= FLUSH_WORD;
      pc_plus4 <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (flush) begin
      inst     <= FLUSH_WORD;
      valid    <= 1'b0;
    end else if (load) begin
      inst     <= d_inst;
      pc_plus4 <= d_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect mux, Halt freeze FSM and fetch counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = mips_pkg::OP_HALT,
  parameter logic [31:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  import mips_pkg::fetch_state_t;
  import mips_pkg::FETCH_RUN;
  import mips_pkg::FETCH_HALTED;

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         redirect;
  logic         load;
  logic         flush;
  logic         count_en;

  assign pc_plus4 = pc_out + 32'd4;
  assign redirect = branch_taken | jr_en | jump_en;
  assign halted   = (state == FETCH_HALTED);

  // Redirect target: EX branch over ID jump-register over ID jump, word aligned
  always_comb begin
    redirect_target = 32'h0000_0000;
    if (branch_taken) begin
      redirect_target = branch_target & 32'hFFFF_FFFC;
    end else if (jr_en) begin
      redirect_target = jr_target & 32'hFFFF_FFFC;
    end else begin
      redirect_target = {if_id_pc_plus4[31:28], jump_index, 2'b00};
    end
  end

  // Next PC, IF/ID control and Halt FSM next state
  always_comb begin
    next_pc    = pc_out;
    next_state = state;
    load       = 1'b0;
    flush      = 1'b0;
    count_en   = 1'b0;
    if (redirect) begin
      // A redirect while halted means the Halt came from the wrong path
      next_pc    = redirect_target;
      flush      = 1'b1;
      next_state = FETCH_RUN;
    end else begin
      case (state)
        FETCH_HALTED: begin
          flush = 1'b1;
        end
        FETCH_RUN: begin
          if (stall) begin
            next_pc = pc_out;
          end else begin
            next_pc  = pc_plus4;
            load     = 1'b1;
            count_en = 1'b1;
            if (inst_in[31:26] == HALT_OPCODE) begin
              next_state = FETCH_HALTED;
            end else begin
              next_state = FETCH_RUN;
            end
          end
        end
        default: begin
          next_state = FETCH_RUN;
          flush      = 1'b1;
        end
      endcase
    end
  end

  // PC, FSM state and delivered-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out      <= RESET_PC;
      state       <= FETCH_RUN;
      fetch_count <= 32'h0000_0000;
    end else begin
      pc_out <= next_pc;
      state  <= next_state;
      if (count_en) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_reg #(
    .FLUSH_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (flush),
    .d_inst     (inst_in),
    .d_pc_plus4 (pc_plus4),
    .inst       (if_id_inst),
    .pc_plus4   (if_id_pc_plus4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small combinational instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] ADD_W  = 32'h0022_1820;
  localparam logic [31:0] W5     = 32'h00A5_0020;
  localparam logic [31:0] HALT_W = 32'hB400_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] imem [0:63];
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_en        (jump_en),
    .jump_index     (jump_index),
    .jr_en          (jr_en),
    .jr_target      (jr_target),
    .inst_in        (inst_in),
    .pc_out         (pc_out),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb inst_in = imem[pc_out[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    pc_out,              32'h0);
    check({tag, "_inst"},  if_id_inst,          NOP_W);
    check({tag, "_pc4"},   if_id_pc_plus4,      32'h0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0);
    check({tag, "_halt"},  {31'd0, halted},      32'h0);
    check({tag, "_cnt"},   fetch_count,         32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = ADD_W;
    imem[3] = HALT_W;
    imem[5] = W5;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump_en = 1'b0; jump_index = 26'h0; jr_en = 1'b0; jr_target = 32'h0;
    #1;
    check_reset("rst0");
    #1 reset = 1'b0;

    // three sequential fetches
    step();
    check("seq1_pc", pc_out, 32'd4);
    check("seq1_pc4", if_id_pc_plus4, 32'd4);
    check("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    check("seq1_inst", if_id_inst, ADD_W);
    step();
    check("seq2_pc", pc_out, 32'd8);
    check("seq2_pc4", if_id_pc_plus4, 32'd8);
    check("seq2_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    check("seq3_pc", pc_out, 32'd12);
    check("seq3_pc4", if_id_pc_plus4, 32'd12);
    check("seq3_cnt", fetch_count, 32'd3);
    check("seq3_valid", {31'd0, if_id_valid}, 32'd1);

    // asynchronous reset mid-run
    reset = 1'b1;
    #1;
    check_reset("rst_run");
    #1 reset = 1'b0;

    // JAL index 4 while IF holds address 8
    step();
    step();
    check("pre_jal_pc", pc_out, 32'd8);
    jump_en = 1'b1; jump_index = 26'd4;
    step();
    jump_en = 1'b0;
    check("jal_pc", pc_out, 32'd16);
    check("jal_valid", {31'd0, if_id_valid}, 32'd0);
    check("jal_inst", if_id_inst, NOP_W);
    check("jal_cnt", fetch_count, 32'd2);
    step();
    check("post_jal_pc", pc_out, 32'd20);
    check("post_jal_pc4", if_id_pc_plus4, 32'd20);
    check("post_jal_valid", {31'd0, if_id_valid}, 32'd1);
    check("post_jal_cnt", fetch_count, 32'd3);

    // branch beats jr in the same cycle
    jr_en = 1'b1; jr_target = 32'h14; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    check("prio_pc", pc_out, 32'h40);
    check("prio_valid", {31'd0, if_id_valid}, 32'd0);
    check("prio_cnt", fetch_count, 32'd3);
    jr_target = 32'h16;
    step();
    jr_en = 1'b0;
    check("jr_align_pc", pc_out, 32'h14);
    check("jr_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check("post_jr_pc", pc_out, 32'h18);
    check("post_jr_inst", if_id_inst, W5);
    check("post_jr_cnt", fetch_count, 32'd4);

    // stall for two cycles, then stall with a branch
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", pc_out, 32'h18);
      check("stall_inst", if_id_inst, W5);
      check("stall_valid", {31'd0, if_id_valid}, 32'd1);
      check("stall_cnt", fetch_count, 32'd4);
    end
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    check("stall_br_pc", pc_out, 32'h20);
    check("stall_br_valid", {31'd0, if_id_valid}, 32'd0);
    check("stall_br_inst", if_id_inst, NOP_W);
    check("stall_br_cnt", fetch_count, 32'd4);

    // run into the Halt at address 12
    branch_taken = 1'b1; branch_target = 32'd8;
    step();
    branch_taken = 1'b0;
    check("to8_pc", pc_out, 32'd8);
    step();
    check("pre_halt_pc", pc_out, 32'd12);
    check("pre_halt_cnt", fetch_count, 32'd5);
    check("pre_halt_halted", {31'd0, halted}, 32'd0);
    step();
    check("halt_inst", if_id_inst, HALT_W);
    check("halt_valid", {31'd0, if_id_valid}, 32'd1);
    check("halt_pc", pc_out, 32'd16);
    check("halt_pc4", if_id_pc_plus4, 32'd16);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_cnt", fetch_count, 32'd6);
    for (int i = 0; i < 10; i++) begin
      stall = (i >= 3 && i < 6);
      step();
      check("halted_pc", pc_out, 32'd16);
      check("halted_valid", {31'd0, if_id_valid}, 32'd0);
      check("halted_inst", if_id_inst, NOP_W);
      check("halted_flag", {31'd0, halted}, 32'd1);
      check("halted_cnt", fetch_count, 32'd6);
    end
    stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'd4;
    step();
    branch_taken = 1'b0;
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    check("unhalt_pc", pc_out, 32'd4);
    check("unhalt_valid", {31'd0, if_id_valid}, 32'd0);
    check("unhalt_cnt", fetch_count, 32'd6);

    // halt again, then reset while halted
    step();
    step();
    check("rehalt_pre_cnt", fetch_count, 32'd8);
    step();
    check("rehalt_flag", {31'd0, halted}, 32'd1);
    check("rehalt_pc", pc_out, 32'd16);
    reset = 1'b1;
    #1;
    check_reset("rst_halted");
    #1 reset = 1'b0;

    // reset while stalled
    step();
    check("rs_pc", pc_out, 32'd4);
    stall = 1'b1;
    step();
    check("rs_stall_pc", pc_out, 32'd4);
    check("rs_stall_cnt", fetch_count, 32'd1);
    reset = 1'b1;
    #1;
    check_reset("rst_stalled");
    #1 reset = 1'b0; stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
